// File: rtl/panda_pkg.sv
// Shared types for the Panda fetch unit.
// - fetch_state_e : fetch sequencer states
// - fetch_entry_t : one prefetch FIFO entry {instruction word, its PC}
package panda_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned ENTRY_W = 2 * XLEN;

  typedef enum logic [1:0] {
    FETCH_BOOT  = 2'd0,
    FETCH_RUN   = 2'd1,
    FETCH_DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/panda_fifo.sv
// Synchronous FIFO with flush; the head entry is presented on data_o.
// Ports: clk_i/rst_ni, flush_i (empties the FIFO, wins over push/pop),
//        push_i/data_i, pop_i, data_o (head), full_o, empty_o, count_o.
// A push on a full FIFO is accepted only when a pop frees the slot in the same cycle.
module panda_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q;
  logic [PTR_W-1:0] rd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Storage is reset so the head reads as zero out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= ptr_inc(wr_q);
      end
      if (do_pop) rd_q <= ptr_inc(rd_q);
      cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && full_o && !pop_i && !flush_i));

endmodule

// File: rtl/panda_fetch_unit.sv
// Decoupled instruction fetch: req/gnt/rvalid memory side, valid/ready decode side.
// Ports: clk_i/rst_ni; redirect_i/redirect_pc_i (new fetch PC, flush);
//        instr_valid_o/instr_ready_i/instr_o/instr_pc_o toward decode;
//        instr_req_o/instr_addr_o/instr_gnt_i/instr_rvalid_i/instr_rdata_i toward memory.
module panda_fetch_unit
  import panda_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR       = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH      = 2,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i
);

  localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH + 1);

  fetch_state_e      state_q;
  logic [31:0]       fetch_pc_q;
  logic [31:0]       pend_addr_q;
  logic              pend_q;
  logic              stale_q;
  logic [CNT_W-1:0]  out_cnt_q;
  logic [CNT_W-1:0]  discard_q;

  logic              pop;
  logic              gnt_fire;
  logic              rv_fire;
  logic              hold;
  logic              credit;
  logic              push_fifo;
  logic [31:0]       used;
  logic [CNT_W-1:0]  out_next;
  logic [CNT_W-1:0]  redir_discard;

  fetch_entry_t      push_entry;
  fetch_entry_t      head_entry;
  logic              fifo_empty;
  logic              fifo_full;
  logic [FCNT_W-1:0] fifo_count;
  logic [31:0]       pcq_head;
  logic              pcq_full;
  logic              pcq_empty;
  logic [CNT_W-1:0]  pcq_count;
  logic              unused_sink;

  // Request/credit datapath. A same-cycle pop frees a slot so streaming has no bubbles.
  always_comb begin
    pop           = instr_valid_o & instr_ready_i;
    rv_fire       = instr_rvalid_i & (out_cnt_q != '0);
    used          = 32'(out_cnt_q) + 32'(fifo_count) - 32'(pop);
    credit        = (used < FIFO_DEPTH) && (32'(out_cnt_q) < MAX_OUTSTANDING);
    instr_req_o   = pend_q | ((state_q == FETCH_RUN) & credit);
    instr_addr_o  = pend_q ? pend_addr_q : fetch_pc_q;
    gnt_fire      = instr_req_o & instr_gnt_i;
    hold          = instr_req_o & ~instr_gnt_i;
    out_next      = out_cnt_q + CNT_W'(gnt_fire) - CNT_W'(rv_fire);
    // Responses still due after a redirect, plus a held request that is not yet granted.
    redir_discard = out_next + CNT_W'(hold);
    push_fifo     = rv_fire & ~redirect_i & (discard_q == '0);
    push_entry    = '{instr: instr_rdata_i, pc: pcq_head};
  end

  assign instr_valid_o = ~fifo_empty;
  assign instr_o       = head_entry.instr;
  assign instr_pc_o    = head_entry.pc;
  assign unused_sink   = ^{fifo_full, pcq_full, pcq_empty, pcq_count, redirect_pc_i[1:0]};

  // Sequencer: state, fetch PC, in-flight and discard counters, held request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= FETCH_BOOT;
      fetch_pc_q  <= BOOT_ADDR;
      pend_addr_q <= '0;
      pend_q      <= 1'b0;
      stale_q     <= 1'b0;
      out_cnt_q   <= '0;
      discard_q   <= '0;
    end else begin
      out_cnt_q <= out_next;
      pend_q    <= hold;
      if (hold) pend_addr_q <= instr_addr_o;
      if (redirect_i) begin
        fetch_pc_q <= {redirect_pc_i[31:2], 2'b00};
        discard_q  <= redir_discard;
        stale_q    <= hold;
        state_q    <= (redir_discard != '0) ? FETCH_DRAIN : FETCH_RUN;
      end else begin
        if (gnt_fire) stale_q <= 1'b0;
        // A stale held request completes at its old address without advancing the PC.
        if (gnt_fire && !(pend_q && stale_q)) fetch_pc_q <= fetch_pc_q + 32'd4;
        if (rv_fire && (discard_q != '0)) discard_q <= discard_q - CNT_W'(1);
        case (state_q)
          FETCH_BOOT:  state_q <= FETCH_RUN;
          FETCH_RUN:   state_q <= FETCH_RUN;
          FETCH_DRAIN: begin
            if ((discard_q == '0) || (rv_fire && (discard_q == CNT_W'(1))))
              state_q <= FETCH_RUN;
          end
          default:     state_q <= FETCH_BOOT;
        endcase
      end
    end
  end

  panda_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_prefetch (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (redirect_i),
    .push_i  (push_fifo),
    .data_i  (push_entry),
    .pop_i   (pop),
    .data_o  (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // PCs of granted requests, consumed in order as responses return.
  panda_fifo #(.WIDTH(32), .DEPTH(MAX_OUTSTANDING)) u_pc_queue (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (1'b0),
    .push_i  (gnt_fire),
    .data_i  (instr_addr_o),
    .pop_i   (rv_fire),
    .data_o  (pcq_head),
    .full_o  (pcq_full),
    .empty_o (pcq_empty),
    .count_o (pcq_count)
  );

  a_rvalid_expected: assert property (@(posedge clk_i) disable iff (!rst_ni)
    instr_rvalid_i |-> (out_cnt_q != '0));

endmodule

// File: tb/tb_panda_fetch_unit.sv
// Bench for panda_fetch_unit: in-order memory model with programmable latency,
// a per-cycle vector table for streaming/backpressure, and directed redirect/reset sequences.
module tb_panda_fetch_unit;

  localparam logic [31:0] MAGIC = 32'hC0DE_0000;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i = 1'b0;
  logic        instr_rvalid_i = 1'b0;
  logic [31:0] instr_rdata_i = '0;

  panda_fetch_unit dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .redirect_i     (redirect_i),
    .redirect_pc_i  (redirect_pc_i),
    .instr_valid_o  (instr_valid_o),
    .instr_ready_i  (instr_ready_i),
    .instr_o        (instr_o),
    .instr_pc_o     (instr_pc_o),
    .instr_req_o    (instr_req_o),
    .instr_addr_o   (instr_addr_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    int unsigned due;
    logic [31:0] addr;
  } rsp_t;

  typedef struct {
    bit          rst;
    logic        ready;
    logic        gnt;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  rsp_t        rq[$];
  vec_t        vecs[$];
  int          total = 0;
  int          bad = 0;
  int unsigned cyc = 0;
  int unsigned lat = 1;
  logic        gnt_en = 1'b0;
  bit          found;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge: drive memory side, let combinational outputs settle.
  task automatic cycle_start();
    instr_gnt_i = gnt_en;
    if (rq.size() > 0 && rq[0].due <= cyc) begin
      instr_rvalid_i = 1'b1;
      instr_rdata_i  = rq[0].addr ^ MAGIC;
      void'(rq.pop_front());
    end else begin
      instr_rvalid_i = 1'b0;
      instr_rdata_i  = '0;
    end
    #1;
  endtask

  // Record a grant, advance one clock, return at the next negedge.
  task automatic cycle_end();
    if (instr_req_o && instr_gnt_i) rq.push_back('{cyc + lat, instr_addr_o});
    @(posedge clk_i);
    cyc++;
    @(negedge clk_i);
    redirect_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni         = 1'b0;
    redirect_i     = 1'b0;
    instr_gnt_i    = 1'b0;
    instr_rvalid_i = 1'b0;
    instr_rdata_i  = '0;
    rq.delete();
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    cyc    = 0;
  endtask

  initial begin
    // Streaming: gnt=1, response one cycle later, ready=1.
    vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h04});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h08});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'h0C});
    // Backpressure: two grants fill the FIFO, then ready resumes at 0x8.
    vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h00});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h00});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h00});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h04});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h08});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'h0C});

    // Reset state.
    #2;
    chk("rst.valid", 32'(instr_valid_o), 32'h0);
    chk("rst.req",   32'(instr_req_o),   32'h0);
    chk("rst.addr",  instr_addr_o,       32'h0);
    chk("rst.instr", instr_o,            32'h0);
    chk("rst.pc",    instr_pc_o,         32'h0);

    lat = 1;
    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      instr_ready_i = vecs[i].ready;
      gnt_en        = vecs[i].gnt;
      cycle_start();
      chk($sformatf("v%0d.req", i), 32'(instr_req_o), 32'(vecs[i].exp_req));
      if (vecs[i].exp_req) chk($sformatf("v%0d.addr", i), instr_addr_o, vecs[i].exp_addr);
      chk($sformatf("v%0d.valid", i), 32'(instr_valid_o), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
        chk($sformatf("v%0d.pc", i), instr_pc_o, vecs[i].exp_pc);
        chk($sformatf("v%0d.instr", i), instr_o, vecs[i].exp_pc ^ MAGIC);
      end
      cycle_end();
    end

    // Held request across a redirect: address stays until gnt, its response is dropped.
    do_reset();
    instr_ready_i = 1'b1; lat = 1; gnt_en = 1'b0;
    cycle_start(); cycle_end();
    cycle_start();
    chk("hold.req1", 32'(instr_req_o), 32'h1);
    chk("hold.addr1", instr_addr_o, 32'h0);
    cycle_end();
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0100;
    cycle_start();
    chk("hold.addr2", instr_addr_o, 32'h0);
    cycle_end();
    cycle_start();
    chk("hold.req3", 32'(instr_req_o), 32'h1);
    chk("hold.addr3", instr_addr_o, 32'h0);
    cycle_end();
    gnt_en = 1'b1;
    cycle_start();
    chk("hold.addr4", instr_addr_o, 32'h0);
    cycle_end();
    cycle_start();
    chk("hold.drain_req", 32'(instr_req_o), 32'h0);
    chk("hold.drain_valid", 32'(instr_valid_o), 32'h0);
    cycle_end();
    cycle_start();
    chk("hold.new_req", 32'(instr_req_o), 32'h1);
    chk("hold.new_addr", instr_addr_o, 32'h0000_0100);
    cycle_end();
    cycle_start();
    chk("hold.valid7", 32'(instr_valid_o), 32'h0);
    cycle_end();
    cycle_start();
    chk("hold.valid8", 32'(instr_valid_o), 32'h1);
    chk("hold.pc8", instr_pc_o, 32'h0000_0100);
    chk("hold.instr8", instr_o, 32'h0000_0100 ^ MAGIC);
    cycle_end();

    // Two outstanding, redirect to an unaligned PC: both responses drained.
    do_reset();
    instr_ready_i = 1'b1; lat = 3; gnt_en = 1'b1;
    cycle_start(); cycle_end();
    cycle_start(); chk("drain.addr1", instr_addr_o, 32'h0); cycle_end();
    cycle_start();
    chk("drain.req2", 32'(instr_req_o), 32'h1);
    chk("drain.addr2", instr_addr_o, 32'h4);
    cycle_end();
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_2002;
    cycle_start(); chk("drain.req3", 32'(instr_req_o), 32'h0); cycle_end();
    cycle_start();
    chk("drain.req4", 32'(instr_req_o), 32'h0);
    chk("drain.valid4", 32'(instr_valid_o), 32'h0);
    cycle_end();
    cycle_start(); chk("drain.req5", 32'(instr_req_o), 32'h0); cycle_end();
    cycle_start();
    chk("drain.req6", 32'(instr_req_o), 32'h1);
    chk("drain.addr6", instr_addr_o, 32'h0000_2000);
    cycle_end();
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      cycle_start();
      if (instr_valid_o) begin
        found = 1'b1;
        chk("drain.first_pc", instr_pc_o, 32'h0000_2000);
      end
      cycle_end();
    end
    chk("drain.seen", 32'(found), 32'h1);

    // Redirect coinciding with rvalid and a pop: response dropped, FIFO empty.
    do_reset();
    instr_ready_i = 1'b1; lat = 1; gnt_en = 1'b1;
    for (int k = 0; k < 3; k++) begin cycle_start(); cycle_end(); end
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0300;
    cycle_start();
    chk("same.valid3", 32'(instr_valid_o), 32'h1);
    chk("same.pc3", instr_pc_o, 32'h0);
    chk("same.rvalid3", 32'(instr_rvalid_i), 32'h1);
    cycle_end();
    cycle_start();
    chk("same.valid4", 32'(instr_valid_o), 32'h0);
    cycle_end();
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      cycle_start();
      if (instr_valid_o) begin
        found = 1'b1;
        chk("same.first_pc", instr_pc_o, 32'h0000_0300);
        chk("same.first_instr", instr_o, 32'h0000_0300 ^ MAGIC);
      end
      cycle_end();
    end
    chk("same.seen", 32'(found), 32'h1);

    // PC wrap, then asynchronous reset mid-stream.
    do_reset();
    instr_ready_i = 1'b1; lat = 1; gnt_en = 1'b1;
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    cycle_start(); chk("wrap.boot_req", 32'(instr_req_o), 32'h0); cycle_end();
    cycle_start(); chk("wrap.addr1", instr_addr_o, 32'hFFFF_FFFC); cycle_end();
    cycle_start();
    chk("wrap.req2", 32'(instr_req_o), 32'h1);
    chk("wrap.addr2", instr_addr_o, 32'h0);
    cycle_end();
    cycle_start(); chk("wrap.pc3", instr_pc_o, 32'hFFFF_FFFC); cycle_end();
    cycle_start(); chk("wrap.pc4", instr_pc_o, 32'h0); cycle_end();
    cycle_start();
    chk("mid.valid_before", 32'(instr_valid_o), 32'h1);
    rst_ni = 1'b0;
    instr_rvalid_i = 1'b0;
    #1;
    chk("mid.valid", 32'(instr_valid_o), 32'h0);
    chk("mid.req",   32'(instr_req_o),   32'h0);
    chk("mid.addr",  instr_addr_o,       32'h0);
    chk("mid.instr", instr_o,            32'h0);
    chk("mid.pc",    instr_pc_o,         32'h0);
    do_reset();
    cycle_start(); chk("mid.boot_req", 32'(instr_req_o), 32'h0); cycle_end();
    cycle_start();
    chk("mid.restart_req", 32'(instr_req_o), 32'h1);
    chk("mid.restart_addr", instr_addr_o, 32'h0);
    cycle_end();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
